// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache.
// Holds the miss-handling state encoding and the helpers that derive the
// address-field and age widths from the cache geometry.
package cache_pkg;

  // Controller states: idle lookup, read fill, write-through, one settle cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Number of address bits that select a set.
  function automatic int set_w_f(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width: word address (30 bits) minus the set index.
  function automatic int tag_w_f(input int num_sets);
    return 30 - $clog2(num_sets);
  endfunction

  // Age / way-index width; at least one bit even when there is a single way.
  function automatic int age_w_f(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping for the set-associative cache.
// Each way of each set carries an age; 0 is most recently used and
// NUM_WAYS-1 is least recently used. The ages of a set always form a
// permutation of 0..NUM_WAYS-1.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (ages return to age[s][w] = w)
//   set_i        : set addressed this cycle
//   valid_i      : valid bits of the addressed set (for invalid-way preference)
//   touch_en_i   : mark touch_way_i as most recently used at the clock edge
//   touch_way_i  : way being touched
//   victim_o     : replacement way for the addressed set
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [set_w_f(NUM_SETS)-1:0]      set_i,
  input  logic [NUM_WAYS-1:0]               valid_i,
  input  logic                              touch_en_i,
  input  logic [age_w_f(NUM_WAYS)-1:0]      touch_way_i,
  output logic [age_w_f(NUM_WAYS)-1:0]      victim_o
);

  localparam int AGE_W = age_w_f(NUM_WAYS);

  logic [AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] age_d [NUM_SETS][NUM_WAYS];

  logic [AGE_W-1:0] inv_way_s;
  logic             inv_found_s;
  logic [AGE_W-1:0] lru_way_s;

  // Next ages: the touched way becomes youngest, every younger way ages by one.
  always_comb begin
    age_d = age_q;
    if (touch_en_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == touch_way_i) begin
          age_d[set_i][w] = AGE_W'(0);
        end else if (age_q[set_i][w] < age_q[set_i][touch_way_i]) begin
          age_d[set_i][w] = age_q[set_i][w] + AGE_W'(1);
        end else begin
          age_d[set_i][w] = age_q[set_i][w];
        end
      end
    end else begin
      age_d = age_q;
    end
  end

  // Victim: lowest-index invalid way first, otherwise the oldest way.
  always_comb begin
    inv_way_s   = AGE_W'(0);
    inv_found_s = 1'b0;
    lru_way_s   = AGE_W'(0);
    for (int w = 0; w < NUM_WAYS; w++) begin
      inv_way_s   = (!valid_i[w] && !inv_found_s) ? AGE_W'(w) : inv_way_s;
      inv_found_s = inv_found_s | !valid_i[w];
      lru_way_s   = (age_q[set_i][w] == AGE_W'(NUM_WAYS - 1)) ? AGE_W'(w) : lru_way_s;
    end
    victim_o = inv_found_s ? inv_way_s : lru_way_s;
  end

  // Age storage; reset gives way w the age w so ways fill in index order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative, write-through, one-word-line data cache sitting
// between the memory stage and main data memory. Lookups are combinational;
// read misses fill through a request/acknowledge memory port, stores are
// always written through (updating the line only on a hit, no allocation).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   MemReadM, MemWriteM    : load / store request (never both high)
//   ALUResultM             : byte address ([1:0] ignored)
//   WriteDataM             : store data
//   Data, Hit              : load data of the matching way (0 on miss), hit flag
//   Stall                  : pipeline freeze while a miss or store is in flight
//   mem_req/mem_we         : memory request (held until mem_ack), 1 = write
//   mem_addr/mem_wdata     : word-aligned address, store data
//   mem_rdata/mem_ack      : fill data, one-cycle acknowledge
module assoc_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] Data,
  output logic        Hit,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SET_W = set_w_f(NUM_SETS);
  localparam int TAG_W = tag_w_f(NUM_SETS);
  localparam int AGE_W = age_w_f(NUM_WAYS);

  // Line storage
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_d   [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_d  [NUM_SETS][NUM_WAYS];

  state_e state_q;
  state_e state_d;

  logic [SET_W-1:0]    set_s;
  logic [TAG_W-1:0]    tag_s;
  logic [NUM_WAYS-1:0] hit_vec_s;
  logic                hit_s;
  logic [AGE_W-1:0]    hit_way_s;
  logic [31:0]         hit_data_s;
  logic                access_s;

  logic                touch_en_s;
  logic [AGE_W-1:0]    touch_way_s;
  logic [AGE_W-1:0]    victim_s;
  logic                wr_en_s;
  logic [AGE_W-1:0]    wr_way_s;
  logic [31:0]         wr_data_s;
  logic                stall_s;

  // Byte-offset bits never reach the array or memory port.
  logic                unused_s;
  assign unused_s = ^ALUResultM[1:0];

  assign set_s    = ALUResultM[SET_W+1:2];
  assign tag_s    = ALUResultM[31:SET_W+2];
  assign access_s = MemReadM | MemWriteM;

  // Tag compare across the addressed set; at most one way can match.
  always_comb begin
    hit_vec_s  = '0;
    hit_way_s  = AGE_W'(0);
    hit_data_s = 32'd0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec_s[w] = valid_q[set_s][w] && (tag_q[set_s][w] == tag_s);
      hit_way_s    = hit_vec_s[w] ? AGE_W'(w) : hit_way_s;
      hit_data_s   = hit_data_s | (hit_vec_s[w] ? data_q[set_s][w] : 32'd0);
    end
    hit_s = |hit_vec_s;
  end

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .set_i       (set_s),
    .valid_i     (valid_q[set_s]),
    .touch_en_i  (touch_en_s),
    .touch_way_i (touch_way_s),
    .victim_o    (victim_s)
  );

  // Miss/store controller: next state, line write, LRU touch and stall.
  always_comb begin
    state_d     = state_q;
    touch_en_s  = 1'b0;
    touch_way_s = hit_way_s;
    wr_en_s     = 1'b0;
    wr_way_s    = hit_way_s;
    wr_data_s   = WriteDataM;
    stall_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_s = access_s && (!hit_s || MemWriteM);
        if (MemReadM) begin
          if (hit_s) begin
            touch_en_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d    = S_FILL;
          end
        end else if (MemWriteM) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          wr_en_s     = 1'b1;
          wr_way_s    = victim_s;
          wr_data_s   = mem_rdata;
          touch_en_s  = 1'b1;
          touch_way_s = victim_s;
          state_d     = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITE: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          // Write-through without allocate: only an existing line is updated.
          wr_en_s    = hit_s;
          touch_en_s = hit_s;
          state_d    = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single write port into the line arrays (fill or write-hit update).
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_s) begin
      valid_d[set_s][wr_way_s] = 1'b1;
      tag_d[set_s][wr_way_s]   = tag_s;
      data_d[set_s][wr_way_s]  = wr_data_s;
    end else begin
      data_d = data_q;
    end
  end

  // State and line storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= 32'd0;
        end
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign Data      = hit_data_s;
  assign Hit       = hit_s;
  assign Stall     = stall_s;
  assign mem_req   = (state_q == S_FILL) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = {ALUResultM[31:2], 2'b00};
  assign mem_wdata = WriteDataM;

endmodule
